// File: rtl/sensor_pio_pkg.sv
// Shared definitions for the sensor PIO interrupt master: PIO register
// offsets, service FSM states and the queued event layout.
package sensor_pio_pkg;

    localparam logic [1:0] PIO_DATA = 2'd0;
    localparam logic [1:0] PIO_MASK = 2'd2;
    localparam logic [1:0] PIO_EDGE = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_CAP,
        ST_RD_LVL,
        ST_SMP_LVL,
        ST_CLR,
        ST_SETTLE
    } sensor_state_t;

    typedef struct packed {
        logic [1:0] capture;
        logic [1:0] level;
    } sensor_evt_t;

endpackage

// File: rtl/sensor_evt_fifo.sv
// Synchronous event FIFO; pointers carry one extra wrap bit so full and
// empty are told apart without a separate counter.
module sensor_evt_fifo
    import sensor_pio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic        pop,
    input  sensor_evt_t wr_data,
    output sensor_evt_t rd_data,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;
    sensor_evt_t mem [DEPTH];

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/soc_system_sensor_irq_master.sv
// Avalon-MM initiator that arms the sensor PIO, services its edge interrupt,
// clears exactly the captured bits and queues {capture, level} events.
module soc_system_sensor_irq_master
    import sensor_pio_pkg::*;
#(
    parameter logic [1:0] IRQ_MASK   = 2'b11,
    parameter int         FIFO_DEPTH = 4,
    parameter int         DROP_W     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              irq,
    output logic [1:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [1:0]        evt_capture,
    output logic [1:0]        evt_level,
    output logic [DROP_W-1:0] drop_count,
    output logic              busy
);

    sensor_state_t state;
    logic [1:0]    cap;
    logic [1:0]    lvl;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    sensor_evt_t   new_evt;
    sensor_evt_t   head;
    logic          unused_readdata_bits;

    assign unused_readdata_bits = ^avm_readdata[31:2];

    assign new_evt     = '{capture: cap, level: lvl};
    assign fifo_push   = (state == ST_CLR);
    assign evt_valid   = !fifo_empty;
    assign fifo_pop    = evt_valid && evt_ready;
    assign evt_capture = fifo_empty ? 2'b00 : head.capture;
    assign evt_level   = fifo_empty ? 2'b00 : head.level;

    sensor_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (new_evt),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // NOTE: bus outputs are assigned for the state being entered, so they come straight off flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_INIT;
            cap            <= '0;
            lvl            <= '0;
            avm_address    <= PIO_DATA;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
            busy           <= 1'b0;
        end else begin
            avm_address    <= PIO_DATA;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
            busy           <= 1'b1;
            case (state)
                ST_INIT: begin
                    // Chipselect still low means the mask write has not been issued yet.
                    if (!avm_chipselect) begin
                        avm_address    <= PIO_MASK;
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_writedata  <= {30'b0, IRQ_MASK};
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (irq) begin
                        state          <= ST_RD_CAP;
                        avm_address    <= PIO_EDGE;
                        avm_chipselect <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_RD_CAP: begin
                    state          <= ST_RD_LVL;
                    avm_address    <= PIO_DATA;
                    avm_chipselect <= 1'b1;
                end
                ST_RD_LVL: begin
                    cap   <= avm_readdata[1:0];
                    state <= ST_SMP_LVL;
                end
                ST_SMP_LVL: begin
                    lvl <= avm_readdata[1:0];
                    if (cap == 2'b00) begin
                        state <= ST_SETTLE;
                    end else begin
                        state          <= ST_CLR;
                        avm_address    <= PIO_EDGE;
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_writedata  <= {30'b0, cap};
                    end
                end
                ST_CLR: begin
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (fifo_push && fifo_full && !fifo_pop && (drop_count != {DROP_W{1'b1}})) begin
            drop_count <= drop_count + DROP_W'(1);
        end
    end

endmodule
